// File: rtl/ccg_pkg.sv
// Shared defaults, mode encoding and counter-width helper for the CCG
// mask/reduce pipeline.
package ccg_pkg;

  localparam int DEF_N_IN      = 10;
  localparam int DEF_N_OUT     = 15;
  localparam int DEF_FRAME_LEN = 4;

  localparam logic [DEF_N_IN-1:0]  DEF_AND_MASK = 10'h011;
  localparam logic [DEF_N_IN-1:0]  DEF_XOR_MASK = 10'h3FE;
  localparam logic [DEF_N_OUT-1:0] DEF_OUT_SEL  = 15'h1780;

  typedef enum logic {
    MODE_SAMPLE = 1'b0,
    MODE_FRAME  = 1'b1
  } mode_e;

  // Width needed to hold 0..frame_len (counter never reaches frame_len,
  // but the extra headroom keeps the FRAME_LEN=1 case at one bit).
  function automatic int cnt_w(input int frame_len);
    return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/ccg_mask_reduce.sv
// Combinational masked AND / masked XOR-parity reduction of one sample.
// Unmasked bits are forced to 1 for the AND and to 0 for the XOR, so an
// all-zero mask yields the identity value of each reduction.
module ccg_mask_reduce
  import ccg_pkg::*;
#(
  parameter int                N_IN     = DEF_N_IN,
  parameter logic [N_IN-1:0]   AND_MASK = DEF_AND_MASK,
  parameter logic [N_IN-1:0]   XOR_MASK = DEF_XOR_MASK
) (
  input  logic [N_IN-1:0] x,
  output logic            a,
  output logic            p
);

  assign a = &(x | ~AND_MASK);
  assign p = ^(x & XOR_MASK);

endmodule

// File: rtl/ccg_mask_reduce_pipe.sv
// Two-stage ready/valid pipeline around ccg_mask_reduce. Stage 1 registers
// the reductions; stage 2 either emits them per sample or folds them into
// a frame accumulator and emits once per FRAME_LEN samples. Each output
// bit picks the XOR or AND result according to OUT_SEL.
module ccg_mask_reduce_pipe
  import ccg_pkg::*;
#(
  parameter int                N_IN      = DEF_N_IN,
  parameter int                N_OUT     = DEF_N_OUT,
  parameter logic [N_IN-1:0]   AND_MASK  = DEF_AND_MASK,
  parameter logic [N_IN-1:0]   XOR_MASK  = DEF_XOR_MASK,
  parameter logic [N_OUT-1:0]  OUT_SEL   = DEF_OUT_SEL,
  parameter int                FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_IN-1:0]                x,
  input  logic                           acc_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_OUT-1:0]               f,
  output logic [cnt_w(FRAME_LEN)-1:0]    frame_cnt
);

  localparam int              CNT_W    = cnt_w(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic             red_a;
  logic             red_p;
  logic             s1_valid;
  logic             s1_a;
  logic             s1_p;
  logic             and_acc;
  logic             xor_acc;
  mode_e            mode_q;
  mode_e            eff_mode;
  logic             s2_acc;
  logic             ta;
  logic             tp;
  logic             emit;
  logic [N_OUT-1:0] f_next;

  ccg_mask_reduce #(
    .N_IN     (N_IN),
    .AND_MASK (AND_MASK),
    .XOR_MASK (XOR_MASK)
  ) u_reduce (
    .x (x),
    .a (red_a),
    .p (red_p)
  );

  assign s2_acc   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_acc;

  // Stage-2 decode: the mode is only re-sampled at a frame boundary, and
  // the accumulators sit at their identity values whenever frame_cnt is 0,
  // so ta/tp double as the per-sample result.
  always_comb begin
    eff_mode = (frame_cnt == '0) ? mode_e'(acc_mode) : mode_q;
    ta       = and_acc & s1_a;
    tp       = xor_acc ^ s1_p;
    emit     = (eff_mode == MODE_SAMPLE) || (frame_cnt == LAST_CNT);
    f_next   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      f_next[i] = OUT_SEL[i] ? tp : ta;
    end
  end

  // Stage 1: capture the reductions of each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 1'b0;
      s1_p     <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= red_a;
      s1_p     <= red_p;
    end else if (s2_acc) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, frame accumulator and mode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      f         <= '0;
      frame_cnt <= '0;
      and_acc   <= 1'b1;
      xor_acc   <= 1'b0;
      mode_q    <= MODE_SAMPLE;
    end else if (s2_acc) begin
      if (frame_cnt == '0) begin
        mode_q <= eff_mode;
      end
      if (emit) begin
        f         <= f_next;
        out_valid <= 1'b1;
        frame_cnt <= '0;
        and_acc   <= 1'b1;
        xor_acc   <= 1'b0;
      end else begin
        and_acc   <= ta;
        xor_acc   <= tp;
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
